// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes and control-field values.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier: instruction class flags plus the ALU operation used in EXE.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic       rtype,
    output logic       itype_alu,
    output logic       load,
    output logic       store,
    output logic       branch,
    output logic       jump,
    output logic       halt,
    output logic       undef,
    output logic [2:0] alu_op
);

    always_comb begin
        rtype     = 1'b0;
        itype_alu = 1'b0;
        load      = 1'b0;
        store     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        halt      = 1'b0;
        undef     = 1'b0;
        alu_op    = ALU_ADD;
        case (op)
            OP_ADD:   rtype = 1'b1;
            OP_SUB:   begin rtype = 1'b1; alu_op = ALU_SUB; end
            OP_AND:   begin rtype = 1'b1; alu_op = ALU_AND; end
            OP_SLL:   begin rtype = 1'b1; alu_op = ALU_SLL; end
            OP_ADDIU: itype_alu = 1'b1;
            OP_ANDI:  begin itype_alu = 1'b1; alu_op = ALU_AND; end
            OP_ORI:   begin itype_alu = 1'b1; alu_op = ALU_OR; end
            OP_SLTI:  begin itype_alu = 1'b1; alu_op = ALU_SLT; end
            OP_LW:    load = 1'b1;
            OP_SW:    store = 1'b1;
            OP_BEQ, OP_BNE, OP_BLTZ: begin branch = 1'b1; alu_op = ALU_SUB; end
            OP_J, OP_JR, OP_JAL: jump = 1'b1;
            OP_HALT:  halt = 1'b1;
            default:  undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle IF/ID/EXE/MEM/WB sequencing controller.
// MC_ILLEGAL_TRAP_EN: undefined opcodes set sticky `illegal` and halt; otherwise they retire as NOPs.
module mc_ctrl_unit
    import mc_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       sign,
    output logic       InsMemRW,
    output logic       IRWre,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state
);

    state_t     cur, nxt;
    logic       rtype, itype_alu, load, store, branch, jump, halt, undef;
    logic [2:0] alu_op;
    logic       taken;

    mc_op_decode u_dec (
        .op        (op),
        .rtype     (rtype),
        .itype_alu (itype_alu),
        .load      (load),
        .store     (store),
        .branch    (branch),
        .jump      (jump),
        .halt      (halt),
        .undef     (undef),
        .alu_op    (alu_op)
    );

    assign state = cur;
    assign taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero) ||
                   ((op == OP_BLTZ) && sign);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) cur <= S_IF;
        else       cur <= nxt;
    end

`ifdef MC_ILLEGAL_TRAP_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)                     illegal <= 1'b0;
        else if (cur == S_ID && undef) illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        nxt = S_IF;
        case (cur)
            S_IF:  nxt = S_ID;
            S_ID: begin
                if (halt)
                    nxt = S_HALT;
`ifdef MC_ILLEGAL_TRAP_EN
                else if (undef)
                    nxt = S_HALT;
`endif
                else if (jump || undef)
                    nxt = S_IF;
                else
                    nxt = S_EXE;
            end
            S_EXE: begin
                if (branch)              nxt = S_IF;
                else if (load || store)  nxt = S_MEM;
                else                     nxt = S_WB;
            end
            S_MEM:  nxt = store ? S_IF : S_WB;
            S_WB:   nxt = S_IF;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end

    always_comb begin
        InsMemRW  = 1'b0;
        IRWre     = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = PC_NEXT;
        RegWre    = 1'b0;
        RegDst    = RD_RT;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        halted    = 1'b0;
        case (cur)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
            end
            S_ID: begin
                if (jump) begin
                    PCWre = 1'b1;
                    PCSrc = (op == OP_JR) ? PC_REG : PC_JUMP;
                    if (op == OP_JAL) begin
                        RegWre = 1'b1;
                        RegDst = RD_RA;
                    end
                end
`ifndef MC_ILLEGAL_TRAP_EN
                else if (undef)
                    PCWre = 1'b1;
`endif
            end
            S_EXE: begin
                ALUOp   = alu_op;
                ALUSrcB = itype_alu | load | store;
                if (branch) begin
                    PCWre = 1'b1;
                    PCSrc = taken ? PC_BRANCH : PC_NEXT;
                end
            end
            S_MEM: begin
                if (store) begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                end else begin
                    mRD = 1'b1;
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                RegDst    = rtype ? RD_RD : RD_RT;
                DBDataSrc = load;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
